rm3100_sampler: RTL
===================

Name: rm3100_sampler

Overview:
- Sequencer that owns the RM3100 magnetometer through the existing spi_rm3100 master. It replaces the ad-hoc counter/case readout in the top level.
- After reset it writes the cycle-count and TMRC configuration once. On each sample request it optionally polls DRDY, then reads the nine measurement bytes.
- It presents packed 20-bit X/Y/Z words with a one-cycle valid strobe.
- It sits directly upstream of the UART-packet inserter that patches x/y/z into the ping-pong SPRAM.

Parameters:
- CCR, 16'h0032: cycle count written to the X, Y and Z CCR register pairs.
- TMRC, 8'h0C: value written to register 0x0B.
- POLL_DRDY, 1: 1 = poll STATUS (0x34) bit 7 before reading; 0 = read immediately.
- POLL_LIMIT, 255: maximum STATUS reads before timeout (1..255).

Ports:
- clk  in  1  system clock, shared with the spi_rm3100 instance.
- rst_n  in  1  asynchronous, active-low reset.
- sample_req  in  1  one-cycle pulse requesting one XYZ sample.
- spi_req  out  1  one-cycle transaction request to spi_rm3100 (req).
- spi_wr_en  out  1  1 = register write, 0 = register read.
- spi_data_tx  out  16  [7:0] register address, [15:8] write data (0x00 for reads).
- spi_data_rx  in  8  read byte; valid in the cycle spi_done is high.
- spi_done  in  1  one-cycle pulse at transaction end.
- xdata  out  20  {0x24, 0x25, 0x26[7:4]}.
- ydata  out  20  {0x27, 0x28, 0x29[7:4]}.
- zdata  out  20  {0x2A, 0x2B, 0x2C[7:4]}.
- sample_valid  out  1  one-cycle strobe; x/y/z are updated in the same cycle.
- cfg_done  out  1  high after configuration completes; stays high until reset.
- busy  out  1  high in any state except IDLE.
- timeout  out  1  one-cycle pulse when the DRDY poll limit is exhausted.

Behaviour:
- Reset values:
  - spi_req, spi_wr_en, sample_valid, cfg_done, timeout = 0.
  - spi_data_tx = 16'h0000.
  - x/y/z = 0.
  - busy = 1, because the block leaves reset in CFG.
  - The pending flag is cleared.
- States: CFG, IDLE, POLL, READ, OUT.
- Transaction rule:
  - spi_data_tx and spi_wr_en are set in the same cycle as spi_req. They are held stable until spi_done.
  - spi_req is high for exactly one cycle per transaction and is never reasserted before spi_done.
  - The next spi_req is issued in the cycle after spi_done, giving zero idle cycles between transactions.
- CFG: seven writes, in this order:
  - 0x04 = CCR[15:8], 0x05 = CCR[7:0]
  - 0x06 = CCR[15:8], 0x07 = CCR[7:0]
  - 0x08 = CCR[15:8], 0x09 = CCR[7:0]
  - 0x0B = TMRC
  - The first spi_req is issued on the first clk edge after rst_n deasserts.
  - After the seventh spi_done, set cfg_done = 1 and go to IDLE.
- sample_req:
  - In IDLE, sample_req starts a sample.
  - Outside IDLE (including during CFG), sample_req sets a one-deep pending flag. Further requests while pending are dropped.
  - On entering IDLE with the pending flag set, clear the flag and start immediately, without an idle cycle.
- Starting a sample: go to POLL if POLL_DRDY = 1, otherwise go to READ.
- POLL:
  - Read 0x34 (spi_wr_en = 0).
  - On spi_done with spi_data_rx[7] = 1, go to READ.
  - Otherwise increment the 8-bit poll counter and re-issue the read.
  - When the counter reaches POLL_LIMIT without DRDY: pulse timeout, leave x/y/z unchanged, no sample_valid, go to IDLE.
  - The poll counter is cleared on every sample start.
- READ:
  - Nine reads, addresses 0x24..0x2C ascending.
  - Each byte is captured into a 72-bit shadow register on its spi_done. Outputs do not change mid-burst.
- OUT:
  - One cycle. Load x/y/z from the shadow register and pulse sample_valid.
  - The nibble [3:0] of 0x26/0x29/0x2C is discarded.
  - Then go to IDLE, or start the next sample directly if one is pending.
- Rules:
  - Spurious spi_done in IDLE or OUT is ignored.
  - spi_data_rx is sampled only on spi_done.
- Asynchronous rst_n assertion mid-transaction:
  - All state returns to reset values immediately and spi_req drops.
  - After release, configuration restarts from 0x04.
  - The SPI master is reset from the same rst_n.
- Latency, POLL_DRDY = 0, from sample_req in IDLE: first spi_req on the next edge; sample_valid one cycle after the 9th spi_done.

Test Plan:
- Reset release with the SPI model returning done 20 cycles after each req -> seven writes with spi_data_tx 0x0004, 0x3205, 0x0006, 0x3207, 0x0008, 0x3209, 0x0C0B, all with spi_wr_en = 1 -> cfg_done rises one cycle after the 7th done.
- POLL_DRDY = 0; sample_req with the model returning 0x12, 0x34, 0x5F, 0xAB, 0xCD, 0xE0, 0x01, 0x02, 0x3F for 0x24..0x2C -> xdata = 0x12345, ydata = 0xABCDE, zdata = 0x01023, sample_valid high for exactly one cycle.
- POLL_DRDY = 1; STATUS returns 0x00 twice, then 0x80 -> three 0x34 reads followed by nine data reads -> sample_valid, timeout = 0.
- POLL_LIMIT = 4; STATUS always 0x00 -> exactly 4 reads of 0x34, timeout pulses once, x/y/z unchanged, busy = 0 afterwards.
- Three sample_req pulses during CFG -> exactly one sample burst immediately after CFG, then IDLE.
- rst_n pulsed low during the 5th READ transaction -> outputs at reset values asynchronously, spi_req = 0, and after release configuration restarts at 0x0004.

Source files
------------

// File: rtl/rm3100_sampler.sv
// rm3100_sampler: drives an RM3100 through spi_rm3100. It configures the sensor once after reset,
// then on each sample request it optionally polls DRDY, reads nine bytes and emits packed X/Y/Z words.
//   clk, rst_n                        clock, asynchronous active-low reset
//   sample_req                        one-cycle request for one XYZ sample
//   spi_req/spi_wr_en/spi_data_tx     transaction request to the SPI master ({wdata, addr})
//   spi_data_rx/spi_done              read byte and end-of-transaction pulse from the SPI master
//   xdata/ydata/zdata, sample_valid   20-bit results and their one-cycle strobe
//   cfg_done, busy, timeout           configuration complete, not idle, DRDY poll exhausted
module rm3100_sampler #(
    parameter logic [15:0] CCR        = 16'h0032,
    parameter logic [7:0]  TMRC       = 8'h0C,
    parameter bit          POLL_DRDY  = 1'b1,
    parameter logic [7:0]  POLL_LIMIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_req,
    output logic        spi_req,
    output logic        spi_wr_en,
    output logic [15:0] spi_data_tx,
    input  logic [7:0]  spi_data_rx,
    input  logic        spi_done,
    output logic [19:0] xdata,
    output logic [19:0] ydata,
    output logic [19:0] zdata,
    output logic        sample_valid,
    output logic        cfg_done,
    output logic        busy,
    output logic        timeout
);
    localparam logic [2:0] CFG  = 3'd0;
    localparam logic [2:0] IDLE = 3'd1;
    localparam logic [2:0] POLL = 3'd2;
    localparam logic [2:0] READ = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [71:0] shadow_q, shadow_d;
    logic        pend_q, pend_d;
    logic        wait_q, wait_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [15:0] tx_q, tx_d;
    logic [19:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic        valid_q, valid_d;
    logic        cfg_done_q, cfg_done_d;
    logic        timeout_q, timeout_d;
    logic        go_idle, start, issue, issue_wr;
    logic [15:0] issue_tx;
    logic        done_ok;

    // Configuration write sequence as {data, address}.
    function automatic logic [15:0] cfg_word(input logic [3:0] i);
        if (i == 4'd6)
            return {TMRC, 8'h0B};
        return {i[0] ? CCR[7:0] : CCR[15:8], 8'h04 + {4'h0, i}};
    endfunction

    // spi_done only counts while a transaction of ours is outstanding.
    assign done_ok = wait_q & spi_done;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        wait_d     = wait_q & ~spi_done;
        req_d      = 1'b0;
        wr_d       = wr_q;
        tx_d       = tx_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        valid_d    = 1'b0;
        cfg_done_d = cfg_done_q;
        timeout_d  = 1'b0;
        go_idle    = 1'b0;
        start      = 1'b0;
        issue      = 1'b0;
        issue_wr   = 1'b0;
        issue_tx   = 16'h0000;
        case (state_q)
            CFG: begin
                // Nothing outstanding in CFG only happens straight out of reset.
                if (!wait_q) begin
                    issue    = 1'b1;
                    issue_wr = 1'b1;
                    issue_tx = cfg_word(idx_q);
                end else if (spi_done) begin
                    if (idx_q == 4'd6) begin
                        cfg_done_d = 1'b1;
                        go_idle    = 1'b1;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        issue    = 1'b1;
                        issue_wr = 1'b1;
                        issue_tx = cfg_word(idx_q + 4'd1);
                    end
                end
            end
            IDLE: start = sample_req | pend_q;
            POLL: begin
                if (done_ok) begin
                    if (spi_data_rx[7]) begin
                        state_d  = READ;
                        idx_d    = 4'd0;
                        issue    = 1'b1;
                        issue_tx = 16'h0024;
                    end else if (cnt_q + 8'd1 == POLL_LIMIT) begin
                        timeout_d = 1'b1;
                        go_idle   = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 8'd1;
                        issue    = 1'b1;
                        issue_tx = 16'h0034;
                    end
                end
            end
            READ: begin
                if (done_ok) begin
                    // Byte n of the burst lands at bits [71-8n -: 8], so 0x24 ends up on top.
                    shadow_d[8'd71 - {1'b0, idx_q, 3'b000} -: 8] = spi_data_rx;
                    if (idx_q == 4'd8) begin
                        // Load straight from the next shadow value so sample_valid follows the last done by one cycle.
                        x_d     = shadow_d[71:52];
                        y_d     = shadow_d[47:28];
                        z_d     = shadow_d[23:4];
                        valid_d = 1'b1;
                        state_d = OUT;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        issue    = 1'b1;
                        issue_tx = {8'h00, 8'h25 + {4'h0, idx_q}};
                    end
                end
            end
            OUT: go_idle = 1'b1;
            default: state_d = IDLE;
        endcase
        // Entering IDLE with a request waiting starts the next sample without an idle cycle.
        if (go_idle) begin
            start   = sample_req | pend_q;
            state_d = IDLE;
        end
        if (start) begin
            pend_d   = 1'b0;
            cnt_d    = 8'd0;
            idx_d    = 4'd0;
            state_d  = POLL_DRDY ? POLL : READ;
            issue    = 1'b1;
            issue_wr = 1'b0;
            issue_tx = POLL_DRDY ? 16'h0034 : 16'h0024;
        end else if (sample_req && state_q != IDLE) begin
            pend_d = 1'b1;
        end
        if (issue) begin
            req_d  = 1'b1;
            wait_d = 1'b1;
            wr_d   = issue_wr;
            tx_d   = issue_tx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CFG;
            idx_q      <= 4'd0;
            cnt_q      <= 8'd0;
            shadow_q   <= 72'd0;
            pend_q     <= 1'b0;
            wait_q     <= 1'b0;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            tx_q       <= 16'h0000;
            x_q        <= 20'd0;
            y_q        <= 20'd0;
            z_q        <= 20'd0;
            valid_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            tx_q       <= tx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            valid_q    <= valid_d;
            cfg_done_q <= cfg_done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign spi_req      = req_q;
    assign spi_wr_en    = wr_q;
    assign spi_data_tx  = tx_q;
    assign xdata        = x_q;
    assign ydata        = y_q;
    assign zdata        = z_q;
    assign sample_valid = valid_q;
    assign cfg_done     = cfg_done_q;
    assign busy         = state_q != IDLE;
    assign timeout      = timeout_q;
endmodule
